// File: rtl/mil_word_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : mil_word_transmitter
// Description : Slave end of the IPushMil word interface. Latches one typed
//               1553 word per request and drives it onto the transceiver as
//               Manchester-II biphase: 3-bit sync, 16 data bits MSB first,
//               odd parity. Pulses mil_done once the word has left the line.
// Revision    : 1.0 - initial release
// ============================================================================
module mil_word_transmitter #(
  parameter int CLK_PER_HALFBIT = 25,
  parameter int GAP_HALFBITS    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mil_request,
  input  logic [1:0]  mil_data_type,
  input  logic [15:0] mil_data_word,
  output logic        mil_done,
  output logic        line_p,
  output logic        line_n,
  output logic        tx_en,
  output logic        busy
);

  localparam int TIMER_W = $clog2(CLK_PER_HALFBIT);
  localparam int INDEX_W = $clog2(40);
  localparam int GAP_W   = (GAP_HALFBITS > 1) ? $clog2(GAP_HALFBITS) : 1;

  localparam logic [TIMER_W-1:0] c_timerLast  = TIMER_W'(CLK_PER_HALFBIT - 1);
  localparam logic [INDEX_W-1:0] c_syncSwap   = INDEX_W'(3);
  localparam logic [INDEX_W-1:0] c_syncLast   = INDEX_W'(5);
  localparam logic [INDEX_W-1:0] c_dataLast   = INDEX_W'(37);
  localparam logic [INDEX_W-1:0] c_parityLast = INDEX_W'(39);
  localparam logic [GAP_W-1:0]   c_gapLast    = GAP_W'((GAP_HALFBITS > 0) ? GAP_HALFBITS - 1 : 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    DONE   = 3'd4,
    GAP    = 3'd5
  } state_t;

  state_t               r_state;
  logic [TIMER_W-1:0]   r_timer;
  logic [INDEX_W-1:0]   r_index;
  logic [GAP_W-1:0]     r_gapCount;
  // Word followed by the parity bit to send; the MSB is the bit on the line.
  logic [16:0]          r_shift;
  // 1 for command/status sync (high first), 0 for data sync (low first).
  logic                 r_cmdSync;

  state_t               w_stateNext;
  logic [TIMER_W-1:0]   w_timerNext;
  logic [INDEX_W-1:0]   w_indexNext;
  logic [GAP_W-1:0]     w_gapNext;
  logic [16:0]          w_shiftNext;
  logic                 w_cmdSyncNext;
  logic                 w_timerEnd;
  logic                 w_drive;
  logic                 w_level;

  // Next-state, counter and line-level decode for the current half-bit
  always_comb begin
    w_stateNext   = r_state;
    w_timerNext   = r_timer;
    w_indexNext   = r_index;
    w_gapNext     = r_gapCount;
    w_shiftNext   = r_shift;
    w_cmdSyncNext = r_cmdSync;
    w_drive       = 1'b0;
    w_level       = 1'b0;
    w_timerEnd    = (r_timer == c_timerLast);

    case (r_state)
      IDLE: begin
        w_timerNext = '0;
        w_indexNext = '0;
        w_gapNext   = '0;
        if (mil_request) begin
          w_stateNext   = SYNC;
          // Correct parity is ~^word; error types (type[0]=0) invert it,
          // which collapses to ^word ^ type[0].
          w_shiftNext   = {mil_data_word, (^mil_data_word) ^ mil_data_type[0]};
          w_cmdSyncNext = ~mil_data_type[1];
        end
      end

      SYNC, DATA, PARITY: begin
        w_drive = 1'b1;
        if (r_state == SYNC) begin
          w_level = r_cmdSync ^ (r_index >= c_syncSwap);
        end else begin
          // Even index is the first half of a bit (bit value), odd the second.
          w_level = r_shift[16] ^ r_index[0];
        end
        w_timerNext = w_timerEnd ? '0 : r_timer + 1'b1;
        if (w_timerEnd) begin
          w_indexNext = r_index + 1'b1;
          if ((r_state != SYNC) && r_index[0]) begin
            w_shiftNext = {r_shift[15:0], 1'b0};
          end
          if ((r_state == SYNC) && (r_index == c_syncLast)) begin
            w_stateNext = DATA;
          end
          if ((r_state == DATA) && (r_index == c_dataLast)) begin
            w_stateNext = PARITY;
          end
          if ((r_state == PARITY) && (r_index == c_parityLast)) begin
            w_stateNext = DONE;
            w_indexNext = '0;
          end
        end
      end

      DONE: begin
        w_timerNext = '0;
        w_indexNext = '0;
        w_gapNext   = '0;
        w_stateNext = (GAP_HALFBITS > 0) ? GAP : IDLE;
      end

      GAP: begin
        w_timerNext = w_timerEnd ? '0 : r_timer + 1'b1;
        if (w_timerEnd) begin
          w_gapNext = r_gapCount + 1'b1;
          if (r_gapCount == c_gapLast) begin
            w_stateNext = IDLE;
            w_gapNext   = '0;
          end
        end
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State/counter registers and registered line, busy and done outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_index    <= '0;
      r_gapCount <= '0;
      r_shift    <= '0;
      r_cmdSync  <= 1'b0;
      line_p     <= 1'b0;
      line_n     <= 1'b0;
      tx_en      <= 1'b0;
      busy       <= 1'b0;
      mil_done   <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_timer    <= w_timerNext;
      r_index    <= w_indexNext;
      r_gapCount <= w_gapNext;
      r_shift    <= w_shiftNext;
      r_cmdSync  <= w_cmdSyncNext;
      line_p     <= w_drive & w_level;
      line_n     <= w_drive & ~w_level;
      tx_en      <= w_drive;
      busy       <= (r_state != IDLE);
      mil_done   <= (r_state == DONE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mil_word_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mil_word_transmitter
// Description : Self-checking bench. Two transmitters (gap 0 and gap 8) share
//               one stimulus stream; each is compared cycle by cycle against a
//               word-level timing model built from the line protocol rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mil_word_transmitter;

  localparam int CPH      = 4;
  localparam int WORD_CYC = 40 * CPH;
  localparam logic [1:0] WSERVERR = 2'd0;
  localparam logic [1:0] WSERV    = 2'd1;
  localparam logic [1:0] WDATAERR = 2'd2;
  localparam logic [1:0] WDATA    = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        milRequest = 1'b0;
  logic [1:0]  milDataType = 2'd0;
  logic [15:0] milDataWord = 16'd0;
  logic [1:0]  milDone, lineP, lineN, txEn, busy;

  int nChecks = 0;
  int nFail   = 0;
  int cyc     = 0;
  bit armed   = 1'b0;

  // Model state per DUT: 0 = no gap, 1 = 8 half-bit gap
  bit          act[2];
  int          startEdge[2];
  int          nextFree[2];
  logic [39:0] lv[2];
  int          gapCyc[2];

  mil_word_transmitter #(.CLK_PER_HALFBIT(CPH), .GAP_HALFBITS(0)) dut0 (
    .clk(clk), .rst(rst), .mil_request(milRequest), .mil_data_type(milDataType),
    .mil_data_word(milDataWord), .mil_done(milDone[0]), .line_p(lineP[0]),
    .line_n(lineN[0]), .tx_en(txEn[0]), .busy(busy[0]));

  mil_word_transmitter #(.CLK_PER_HALFBIT(CPH), .GAP_HALFBITS(8)) dutGap (
    .clk(clk), .rst(rst), .mil_request(milRequest), .mil_data_type(milDataType),
    .mil_data_word(milDataWord), .mil_done(milDone[1]), .line_p(lineP[1]),
    .line_n(lineN[1]), .tx_en(txEn[1]), .busy(busy[1]));

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // Half-bit levels of a whole word, element i is half-bit i on the line
  function automatic logic [39:0] halfBits(input logic [1:0] t, input logic [15:0] w);
    logic [39:0] h;
    logic cmd, p;
    h = '0;
    cmd = (t == WSERV) || (t == WSERVERR);
    for (int i = 0; i < 6; i++) h[i] = (i < 3) ? cmd : !cmd;
    for (int b = 0; b < 16; b++) begin
      h[6 + 2 * b] = w[15 - b];
      h[7 + 2 * b] = !w[15 - b];
    end
    p = (($countones(w) % 2) == 0);
    if (t == WSERVERR || t == WDATAERR) p = !p;
    h[38] = p;
    h[39] = !p;
    return h;
  endfunction

  // Advance the model at each edge, then compare both DUTs just after it
  always @(posedge clk) begin
    int off;
    logic [4:0] exp, got;
    cyc = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        act[d] = 1'b0;
        nextFree[d] = cyc + 1;
      end else if (milRequest && cyc >= nextFree[d]) begin
        act[d] = 1'b1;
        startEdge[d] = cyc;
        lv[d] = halfBits(milDataType, milDataWord);
        nextFree[d] = cyc + WORD_CYC + 2 + gapCyc[d];
      end
    end
    if (rst) armed = 1'b1;
    #1;
    if (armed) begin
      for (int d = 0; d < 2; d++) begin
        exp = 5'b0;
        if (act[d]) begin
          off = cyc - startEdge[d];
          if (off >= 1 && off <= WORD_CYC) begin
            exp[4] = lv[d][(off - 1) / CPH];
            exp[3] = !lv[d][(off - 1) / CPH];
            exp[2] = 1'b1;
          end
          exp[1] = (off >= 1 && off <= WORD_CYC + 1 + gapCyc[d]);
          exp[0] = (off == WORD_CYC + 1);
        end
        got = {lineP[d], lineN[d], txEn[d], busy[d], milDone[d]};
        checkEq(d == 0 ? "dut0 {p,n,tx,busy,done}" : "dutGap {p,n,tx,busy,done}",
                {27'd0, got}, {27'd0, exp});
      end
    end
  end

  task automatic waitIdle();
    while (cyc + 1 < nextFree[0] || cyc + 1 < nextFree[1]) @(negedge clk);
  endtask

  task automatic pulse(input logic [1:0] t, input logic [15:0] w);
    milDataType = t;
    milDataWord = w;
    milRequest  = 1'b1;
    @(negedge clk);
    milRequest  = 1'b0;
    milDataWord = ~w;
    milDataType = ~t;
  endtask

  task automatic sendWord(input logic [1:0] t, input logic [15:0] w);
    waitIdle();
    pulse(t, w);
  endtask

  initial begin
    int s;
    int guard;
    gapCyc[0] = 0;
    gapCyc[1] = 8 * CPH;
    for (int d = 0; d < 2; d++) begin
      act[d] = 1'b0; startEdge[d] = 0; nextFree[d] = 0; lv[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // A5A5 data word with an ignored second request mid-word
    sendWord(WDATA, 16'hA5A5);
    repeat (49) @(negedge clk);
    pulse(WSERV, 16'h0F0F);

    sendWord(WSERV, 16'hFFA1);
    sendWord(WDATAERR, 16'h0001);
    sendWord(WSERVERR, 16'h0000);

    // Reset mid-DATA, then a word in the first IDLE cycle after reset
    sendWord(WDATA, 16'hBEEF);
    repeat (69) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulse(WDATA, 16'h1234);

    // Reset and request together: request dropped
    waitIdle();
    rst = 1'b1;
    milRequest = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    milRequest = 1'b0;
    repeat (5) @(negedge clk);

    // Gap: second request held high every cycle until the gap DUT accepts it
    sendWord(WDATA, 16'h5A5A);
    s = startEdge[1];
    guard = 0;
    milDataType = WSERV;
    milDataWord = 16'h8001;
    milRequest  = 1'b1;
    while (startEdge[1] == s && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    milRequest = 1'b0;
    if (guard >= 400) checkEq("gap acceptance timeout", 32'd0, 32'd1);

    // Randomized traffic with occasional resets and requests while busy
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      milRequest  = ($urandom_range(0, 15) == 0);
      milDataType = 2'($urandom_range(0, 3));
      milDataWord = 16'($urandom);
      rst         = ($urandom_range(0, 1999) == 0);
    end
    milRequest = 1'b0;
    rst = 1'b0;
    waitIdle();
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
